// File: rtl/rs_issue.sv
// rs_issue: consumer side of the reservation station.
// Captures full+ready slots into per-unit issue registers and hands them off.
module rs_issue #(
  parameter int BWIDTH = 57,
  parameter int SLOTS  = 5,
  parameter int CWIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [SLOTS*BWIDTH-1:0] i_slot_bundle,
  input  logic [SLOTS-1:0]        i_slot_full,
  input  logic [SLOTS-1:0]        i_slot_rdy,
  output logic [SLOTS-1:0]        o_slot_clear,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic [SLOTS-1:0]        o_fu_valid,
  output logic [SLOTS*BWIDTH-1:0] o_fu_bundle,
  input  logic [SLOTS-1:0]        i_fu_ready,
  output logic [CWIDTH-1:0]       o_issue_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [SLOTS-1:0]  accept;
  logic [SLOTS-1:0]  free;
  logic [SLOTS-1:0]  load;
  logic [CWIDTH-1:0] inc;
  logic [CWIDTH-1:0] count;

  // A slot may capture when its register is empty or drains this cycle.
  always_comb begin
    accept = o_fu_valid & i_fu_ready;
    free   = ~o_fu_valid | accept;
    load   = i_slot_full & i_slot_rdy & free;
    if (i_stall || i_flush || i_rst) begin
      load = '0;
    end
  end

  assign o_slot_clear = load;

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    state_t            state;
    logic [BWIDTH-1:0] bund;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state <= IDLE;
        bund  <= '0;
      end else begin
        if (load[k]) begin
          bund <= i_slot_bundle[k*BWIDTH +: BWIDTH];
        end
        if (i_flush) begin
          state <= IDLE;
        end else begin
          unique case (state)
            IDLE: if (load[k]) state <= HOLD;
            HOLD: if (accept[k] && !load[k]) state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end

    assign o_fu_valid[k]                    = (state == HOLD);
    assign o_fu_bundle[k*BWIDTH +: BWIDTH] = bund;
  end

  // Handshakes still count under flush: the unit took the bundle.
  always_comb begin
    inc = '0;
    for (int k = 0; k < SLOTS; k++) begin
      inc = inc + CWIDTH'(accept[k]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else begin
      count <= count + inc;
    end
  end

  assign o_issue_count = count;

endmodule

// File: tb/tb_rs_issue.sv
// Self-checking bench for rs_issue.
// A slot-level reference model predicts clears, valids, bundles and counts.
module tb_rs_issue;
  localparam int BW = 57;
  localparam int NS = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NS*BW-1:0] sbund = '0;
  logic [NS-1:0]   full = '0;
  logic [NS-1:0]   rdy = '0;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic [NS-1:0]   fu_rdy = '0;

  logic [NS-1:0]    clear, clear_w;
  logic [NS-1:0]    fval, fval_w;
  logic [NS*BW-1:0] fbun, fbun_w;
  logic [31:0]      count;
  logic [2:0]       count_w;

  // reference model state
  bit          mv[NS];
  logic [BW-1:0] mb[NS];
  logic [31:0] mc;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  rs_issue dut (
    .i_clk(clk), .i_rst(rst), .i_slot_bundle(sbund),
    .i_slot_full(full), .i_slot_rdy(rdy), .o_slot_clear(clear),
    .i_stall(stall), .i_flush(flush), .o_fu_valid(fval),
    .o_fu_bundle(fbun), .i_fu_ready(fu_rdy), .o_issue_count(count)
  );

  rs_issue #(.CWIDTH(3)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_slot_bundle(sbund),
    .i_slot_full(full), .i_slot_rdy(rdy), .o_slot_clear(clear_w),
    .i_stall(stall), .i_flush(flush), .o_fu_valid(fval_w),
    .o_fu_bundle(fbun_w), .i_fu_ready(fu_rdy), .o_issue_count(count_w)
  );

  function automatic logic [BW-1:0] rnd_b();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] bun_of(input logic [NS*BW-1:0] v,
                                           input int k);
    return v[k*BW +: BW];
  endfunction

  function automatic logic [NS-1:0] mvalid();
    logic [NS-1:0] v;
    for (int k = 0; k < NS; k++) v[k] = mv[k];
    return v;
  endfunction

  // A slot is cleared iff full, ready, its unit register is free, no hold.
  function automatic logic [NS-1:0] exp_clear();
    logic [NS-1:0] c;
    for (int k = 0; k < NS; k++)
      c[k] = full[k] && rdy[k] && (!mv[k] || fu_rdy[k])
             && !stall && !flush && !rst;
    return c;
  endfunction

  task automatic model_edge();
    logic [NS-1:0] ld;
    int n;
    ld = exp_clear();
    n = 0;
    for (int k = 0; k < NS; k++) if (mv[k] && fu_rdy[k]) n++;
    mc = mc + 32'(n);
    for (int k = 0; k < NS; k++) begin
      if (ld[k]) mb[k] = bun_of(sbund, k);
      if (flush) mv[k] = 0;
      else if (ld[k]) mv[k] = 1;
      else if (mv[k] && fu_rdy[k]) mv[k] = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    for (int k = 0; k < NS; k++) begin
      mv[k] = 0;
      mb[k] = '0;
    end
    mc = '0;
    full = '0; rdy = '0; fu_rdy = '0; stall = 0; flush = 0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; full = '1; rdy = '1; fu_rdy = '1;
    #1;
    total++;
    if (clear !== 5'b0) $display("FAIL reset_clear: got %b want 00000", clear);
    else pass++;
    @(posedge clk); #1;
    total++;
    if (fval !== 5'b0 || fbun !== '0 || count !== 32'd0)
      $display("FAIL reset_state: got v=%b c=%0d want v=0 c=0", fval, count);
    else pass++;
    do_reset();
  endtask

  task automatic test_single();
    sbund[2*BW +: BW] = 57'h0AB_CDEF;
    full = 5'b00100; rdy = 5'b00100; fu_rdy = '1;
    #1;
    total++;
    if (clear !== 5'b00100) $display("FAIL single_clear: got %b want 00100", clear);
    else pass++;
    tick();
    full = '0; rdy = '0;
    #1;
    total++;
    if (fval !== 5'b00100 || bun_of(fbun, 2) !== 57'h0AB_CDEF)
      $display("FAIL single_issue: got v=%b b=%h want v=00100 b=0abcdef",
               fval, bun_of(fbun, 2));
    else pass++;
    total++;
    if (clear !== 5'b0) $display("FAIL single_clear_once: got %b want 0", clear);
    else pass++;
    tick();
    total++;
    if (count !== 32'd1 || fval !== 5'b0)
      $display("FAIL single_count: got c=%0d v=%b want c=1 v=0", count, fval);
    else pass++;
  endtask

  task automatic test_hold();
    logic [BW-1:0] a, b;
    a = rnd_b(); b = rnd_b();
    sbund[0 +: BW] = a;
    full = 5'b00001; rdy = 5'b00001; fu_rdy = 5'b0;
    tick();
    sbund[0 +: BW] = b;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (clear[0] !== 1'b0 || fval[0] !== 1'b1 || bun_of(fbun, 0) !== a)
        $display("FAIL hold_stable: got c=%b v=%b b=%h want c=0 v=1 b=%h",
                 clear[0], fval[0], bun_of(fbun, 0), a);
      else pass++;
      tick();
    end
    fu_rdy = 5'b00001;
    #1;
    total++;
    if (clear[0] !== 1'b1) $display("FAIL b2b_clear: got %b want 1", clear[0]);
    else pass++;
    tick();
    full = '0; rdy = '0; fu_rdy = '0;
    #1;
    total++;
    if (fval[0] !== 1'b1 || bun_of(fbun, 0) !== b || count !== mc)
      $display("FAIL b2b_issue: got v=%b b=%h c=%0d want v=1 b=%h c=%0d",
               fval[0], bun_of(fbun, 0), count, b, mc);
    else pass++;
    fu_rdy = '1;
    tick();
    fu_rdy = '0;
  endtask

  task automatic test_all_slots();
    do_reset();
    full = '1; rdy = '1; fu_rdy = '1;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NS; k++) sbund[k*BW +: BW] = rnd_b();
      #1;
      total++;
      if (clear !== 5'b11111) $display("FAIL all_clear: got %b want 11111", clear);
      else pass++;
      tick();
    end
    total++;
    if (count !== 32'd45) $display("FAIL all_count: got %0d want 45", count);
    else pass++;
    full = '0; rdy = '0;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    full = 5'b01010; rdy = 5'b01010;
    tick();
    full = 5'b10000; rdy = 5'b10000; flush = 1'b1;
    #1;
    total++;
    if (clear !== 5'b0) $display("FAIL flush_clear: got %b want 0", clear);
    else pass++;
    tick();
    flush = 1'b0; full = '0; rdy = '0;
    #1;
    total++;
    if (fval !== 5'b0 || count !== 32'd0)
      $display("FAIL flush_state: got v=%b c=%0d want v=0 c=0", fval, count);
    else pass++;
  endtask

  task automatic test_stall();
    do_reset();
    full = 5'b01000; rdy = 5'b01000;
    tick();
    full = 5'b00100; rdy = 5'b00100; stall = 1'b1; fu_rdy = '1;
    #1;
    total++;
    if (clear !== 5'b0) $display("FAIL stall_clear: got %b want 0", clear);
    else pass++;
    tick();
    total++;
    if (fval !== 5'b0 || count !== 32'd1)
      $display("FAIL stall_accept: got v=%b c=%0d want v=0 c=1", fval, count);
    else pass++;
    stall = 1'b0; full = '0; rdy = '0; fu_rdy = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    full = '1; rdy = '1; fu_rdy = '0;
    tick();
    full = 5'b00001; rdy = 5'b00001; fu_rdy = '1;
    tick();
    full = 5'b00111; rdy = 5'b00111; fu_rdy = 5'b00001;
    tick();
    total++;
    if (count_w !== 3'd6) $display("FAIL wrap_preload: got %0d want 6", count_w);
    else pass++;
    full = '0; rdy = '0; fu_rdy = 5'b00111;
    tick();
    total++;
    if (count_w !== 3'd1 || count !== 32'd9)
      $display("FAIL wrap: got w=%0d c=%0d want w=1 c=9", count_w, count);
    else pass++;
    full = '1; rdy = '1; fu_rdy = '0;
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (fval !== 5'b0 || fbun !== '0 || count !== 32'd0 || clear !== 5'b0)
      $display("FAIL async_reset: got v=%b c=%0d cl=%b want all 0",
               fval, count, clear);
    else pass++;
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NS; k++) sbund[k*BW +: BW] = rnd_b();
      full = NS'($urandom); rdy = NS'($urandom); fu_rdy = NS'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      total++;
      if (clear !== exp_clear())
        $display("FAIL rnd_clear: got %b want %b", clear, exp_clear());
      else pass++;
      tick();
      total++;
      if (fval !== mvalid() || fval_w !== mvalid())
        $display("FAIL rnd_valid: got %b/%b want %b", fval, fval_w, mvalid());
      else pass++;
      total++;
      if (count !== mc || count_w !== mc[2:0])
        $display("FAIL rnd_count: got %0d/%0d want %0d", count, count_w, mc);
      else pass++;
      for (int k = 0; k < NS; k++) begin
        if (mv[k]) begin
          total++;
          if (bun_of(fbun, k) !== mb[k])
            $display("FAIL rnd_bundle%0d: got %h want %h", k, bun_of(fbun, k), mb[k]);
          else pass++;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NS; k++) begin
      mv[k] = 0;
      mb[k] = '0;
    end
    mc = '0;
    test_reset();
    test_single();
    test_hold();
    test_all_slots();
    test_flush();
    test_stall();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/rs_issue.md
Name: rs_issue

Overview:
- Consumer side of the reservation-station slot interface.
- Each cycle it watches every slot's full/ready status. When a slot is both full and ready, it captures that slot's bundle into a per-slot issue register and pulses a clear back to the station in the same cycle.
- It then presents the bundle to the matching execution unit with a valid/ready handshake.
- Sits between the reservation station and the execution units (asb1, asb2, logic, load, store). Also keeps a global issue counter for performance monitoring.

Parameters:
- BWIDTH, 57, bundle width in bits.
- SLOTS, 5, number of station slots; one execution unit per slot, slot index = unit index.
- CWIDTH, 32, width of the issue performance counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_slot_bundle  input  SLOTS*BWIDTH  slot k bundle at bits [k*BWIDTH +: BWIDTH].
- i_slot_full  input  SLOTS  slot k holds an instruction.
- i_slot_rdy  input  SLOTS  both operands of slot k are ready.
- o_slot_clear  output  SLOTS  combinational; station empties slot k at this clock edge.
- i_stall  input  1  global hold; blocks new captures only.
- i_flush  input  1  synchronous; discards all issue registers.
- o_fu_valid  output  SLOTS  issue register k holds a bundle for unit k.
- o_fu_bundle  output  SLOTS*BWIDTH  issue register k contents.
- i_fu_ready  input  SLOTS  unit k accepts this cycle.
- o_issue_count  output  CWIDTH  total handshakes completed since reset.

Behaviour:
- Each slot k has an independent 2-state FSM: IDLE (o_fu_valid[k]=0) and HOLD (o_fu_valid[k]=1).
- accept[k] = o_fu_valid[k] & i_fu_ready[k].
- free[k] = IDLE | accept[k].
- load[k] = i_slot_full[k] & i_slot_rdy[k] & free[k] & !i_stall & !i_flush.
- o_slot_clear[k] = load[k]. It is purely combinational and asserted only in the cycle of capture, so the station never sees a double capture.
- IDLE -> HOLD when load[k]: the issue register is loaded from slot k; latency is 1 cycle from slot-ready to o_fu_valid.
- HOLD, no accept: o_fu_valid and o_fu_bundle stay stable, bit for bit, until accepted. i_stall does not drop a held bundle.
- HOLD, accept and load in the same cycle: back-to-back issue. Stay in HOLD with the new bundle, giving one issue per cycle per unit.
- HOLD, accept and no load: go to IDLE. o_fu_bundle keeps its stale value (don't-care while valid=0).
- i_flush, from any state: all FSMs go to IDLE next edge, and o_slot_clear=0 that cycle (the station flushes itself).
  - An accept coinciding with flush still counts: the unit took the bundle.
- A slot full but not ready, or ready but not full: no capture, no clear.
- Slots are fully independent; there is no arbitration between units.
- o_issue_count increments by popcount(accept) each cycle (0..SLOTS) and wraps modulo 2^CWIDTH. It is not cleared by i_flush.
- Reset, asynchronous, while i_rst=1: all FSMs IDLE, o_fu_valid=0, o_fu_bundle=0, o_issue_count=0.
  - o_slot_clear=0 during reset regardless of inputs.
  - Release mid-operation discards any held bundle. The first capture is possible on the first edge after deassertion.

Test Plan:
- Reset then slot 2 full+rdy with bundle 57'h0AB_CDEF, units ready → o_slot_clear=5'b00100 for one cycle; next cycle o_fu_valid=5'b00100 and o_fu_bundle slot2=57'h0AB_CDEF; o_issue_count=1 after the accept edge.
- Unit 0 held not-ready for 4 cycles, slot 0 refilled and ready meanwhile → bundle A held stable, o_slot_clear[0]=0 throughout. When i_fu_ready[0]=1, A is accepted and B is captured on the same edge; o_fu_valid[0] stays 1.
- All 5 slots ready every cycle for 10 cycles with all units ready → one clear per slot per cycle; o_issue_count=45 (first cycle only loads).
- i_flush asserted while slots 1 and 3 are held, with slot 4 ready → o_fu_valid=0 next cycle, o_slot_clear=0 in the flush cycle, o_issue_count unchanged.
- i_stall=1 with slot 2 ready and idle → no clear, no valid. A bundle already held in unit 3 is still accepted and the count increments.
- Preload o_issue_count to 2^32-2 via stimulus, then 3 accepts in one cycle → o_issue_count wraps to 1. Asynchronous i_rst mid-cycle → outputs 0 immediately, without waiting for a clock edge.
